// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit
// Memory-stage load/store unit: byte-lane store encoding, single-outstanding
// data-memory handshake with timeout, and load sign/zero extension.
// Rev    : 1.0
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [2:0]  ldst_ctrl,
  input  logic [31:0] store_data,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        err,
  output logic        stall
);

  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_ISSUE   = 2'd1;
  localparam logic [1:0]  c_WAIT    = 2'd2;
  localparam logic [1:0]  c_RESP    = 2'd3;
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] r_addr;
  logic [1:0]  r_lane;
  logic [2:0]  r_ctrl;
  logic [3:0]  r_we;
  logic [31:0] r_wdata;
  logic [15:0] r_cnt;
  logic [31:0] r_rsp_data;
  logic        r_err;

  logic        w_is_store;
  logic        w_timeout;
  logic [3:0]  w_we_next;
  logic [31:0] w_wdata_next;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_ext;

  assign w_is_store = r_ctrl[2] & (r_ctrl[1] | r_ctrl[0]);
  assign w_timeout  = (r_cnt == c_TO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (req_valid)      w_next_state = c_ISSUE;
      c_ISSUE: if (dmem_req_ready) w_next_state = w_is_store ? c_RESP : c_WAIT;
      c_WAIT:  if (dmem_resp_valid || w_timeout) w_next_state = c_RESP;
      c_RESP:  if (rsp_ready)      w_next_state = c_IDLE;
      default:                     w_next_state = c_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    dmem_req_valid = (r_state == c_ISSUE);
    rsp_valid      = (r_state == c_RESP);
    stall          = (r_state != c_IDLE);
    req_ready      = (r_state == c_IDLE) && rst_n;
    dmem_addr      = r_addr;
    dmem_we        = r_we;
    dmem_wdata     = r_wdata;
    rsp_data       = r_rsp_data;
    err            = r_err;
  end

  // Store lane encoding from the incoming op
  always_comb begin
    w_we_next    = 4'b0000;
    w_wdata_next = 32'd0;
    case (ldst_ctrl)
      3'b101: begin
        w_we_next    = 4'b0001 << addr[1:0];
        w_wdata_next = {4{store_data[7:0]}};
      end
      3'b110: begin
        w_we_next    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_next = {2{store_data[15:0]}};
      end
      3'b111: begin
        w_we_next    = 4'b1111;
        w_wdata_next = store_data;
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    case (r_lane)
      2'd1:    w_lane_byte = dmem_rdata[15:8];
      2'd2:    w_lane_byte = dmem_rdata[23:16];
      2'd3:    w_lane_byte = dmem_rdata[31:24];
      default: w_lane_byte = dmem_rdata[7:0];
    endcase
    w_lane_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_ctrl)
      3'b000:  w_load_ext = {{24{w_lane_byte[7]}}, w_lane_byte};
      3'b001:  w_load_ext = {{16{w_lane_half[15]}}, w_lane_half};
      3'b011:  w_load_ext = {24'd0, w_lane_byte};
      3'b100:  w_load_ext = {16'd0, w_lane_half};
      default: w_load_ext = dmem_rdata;
    endcase
  end

  // Request fields and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr     <= 32'd0;
      r_lane     <= 2'd0;
      r_ctrl     <= 3'd0;
      r_we       <= 4'd0;
      r_wdata    <= 32'd0;
      r_cnt      <= 16'd0;
      r_rsp_data <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: if (req_valid) begin
          r_addr     <= {addr[31:2], 2'b00};
          r_lane     <= addr[1:0];
          r_ctrl     <= ldst_ctrl;
          r_we       <= w_we_next;
          r_wdata    <= w_wdata_next;
          r_rsp_data <= 32'd0;
          r_err      <= 1'b0;
        end
        c_ISSUE: if (dmem_req_ready) begin
          r_cnt      <= 16'd0;
          r_rsp_data <= 32'd0;
          r_err      <= 1'b0;
        end
        c_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          // A response in the limit cycle still counts as a good load
          if (dmem_resp_valid) begin
            r_rsp_data <= w_load_ext;
            r_err      <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= 32'd0;
            r_err      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_unit
// Randomized bench for mem_access_unit against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, dmem_req_ready, dmem_resp_valid, rsp_ready;
  logic [31:0] addr, store_data, dmem_rdata;
  logic [2:0]  ldst_ctrl;
  logic        req_ready, dmem_req_valid, rsp_valid, err, stall;
  logic [31:0] dmem_addr, dmem_wdata, rsp_data;
  logic [3:0]  dmem_we;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .ldst_ctrl(ldst_ctrl), .store_data(store_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .err(err), .stall(stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle view, set by the transaction driver
  logic        chk_en = 1'b0;
  logic        e_req_ready, e_stall, e_dreq, e_rsp, e_zero;
  logic [31:0] e_addr, e_wdata, e_data;
  logic [3:0]  e_we;
  logic        e_err;

  // Last DUT values seen, for literal spot checks
  logic [31:0] cap_addr, cap_wdata, cap_data;
  logic [3:0]  cap_we;
  logic        cap_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_we(input logic [2:0] c, input logic [31:0] a);
    case (c)
      3'd5:    return 4'(1 << a[1:0]);
      3'd6:    return a[1] ? 4'b1100 : 4'b0011;
      3'd7:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] c, input logic [31:0] sd);
    case (c)
      3'd5:    return {4{sd[7:0]}};
      3'd6:    return {2{sd[15:0]}};
      3'd7:    return sd;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] c, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> (int'(a[1:0]) * 8));
    h = 16'(rd >> (a[1] ? 16 : 0));
    case (c)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return rd;
      3'd3:    return {24'd0, b};
      3'd4:    return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, e_req_ready});
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("dmem_req_valid", {31'd0, dmem_req_valid}, {31'd0, e_dreq});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rsp});
      if (e_dreq) begin
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_we", {28'd0, dmem_we}, {28'd0, e_we});
        chk("dmem_wdata", dmem_wdata, e_wdata);
        cap_addr = dmem_addr; cap_we = dmem_we; cap_wdata = dmem_wdata;
      end
      if (e_rsp) begin
        chk("rsp_data", rsp_data, e_data);
        chk("err", {31'd0, err}, {31'd0, e_err});
        cap_data = rsp_data; cap_err = err;
      end
      if (e_zero) begin
        chk("zero_dmem_addr", dmem_addr, 32'd0);
        chk("zero_dmem_we", {28'd0, dmem_we}, 32'd0);
        chk("zero_dmem_wdata", dmem_wdata, 32'd0);
        chk("zero_rsp_data", rsp_data, 32'd0);
        chk("zero_err", {31'd0, err}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_req_ready = rst_n; e_stall = 1'b0; e_dreq = 1'b0; e_rsp = 1'b0;
  endtask

  // One complete op: req_lat cycles of memory backpressure, response in WAIT
  // cycle resp_lat (none if resp_lat >= TO), rsp_lat cycles of writeback hold.
  task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int req_lat, input int resp_lat,
                       input int rsp_lat, input bit junk);
    bit is_st;
    int n;
    is_st   = (c >= 3'd5);
    e_addr  = {a[31:2], 2'b00};
    e_we    = m_we(c, a);
    e_wdata = m_wdata(c, sd);
    e_err   = !is_st && (resp_lat >= TO);
    e_data  = (is_st || resp_lat >= TO) ? 32'd0 : m_load(c, a, rd);

    req_valid = 1'b1; addr = a; ldst_ctrl = c; store_data = sd;
    set_idle_exp();
    step();
    // Scramble the upstream inputs: the request must already be latched
    req_valid = 1'b0; addr = $urandom; ldst_ctrl = 3'($urandom); store_data = $urandom;
    e_zero = 1'b0; e_req_ready = 1'b0; e_stall = 1'b1; e_dreq = 1'b1;
    for (int k = 0; k <= req_lat; k++) begin
      dmem_req_ready  = (k == req_lat);
      dmem_resp_valid = junk;
      dmem_rdata      = $urandom;
      step();
    end
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; e_dreq = 1'b0;
    if (!is_st) begin
      n = (resp_lat < TO) ? resp_lat + 1 : TO;
      for (int j = 0; j < n; j++) begin
        dmem_resp_valid = (j == resp_lat);
        dmem_rdata      = (j == resp_lat) ? rd : $urandom;
        step();
      end
      dmem_resp_valid = 1'b0;
    end
    e_rsp = 1'b1;
    for (int k = 0; k <= rsp_lat; k++) begin
      rsp_ready = (k == rsp_lat);
      req_valid = junk && (k < rsp_lat);
      ldst_ctrl = 3'($urandom);
      addr      = $urandom;
      step();
    end
    rsp_ready = 1'b0; req_valid = 1'b0;
    set_idle_exp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; addr = 32'd0; ldst_ctrl = 3'd0; store_data = 32'd0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    set_idle_exp(); e_zero = 1'b1; chk_en = 1'b1;
    step();
    rst_n = 1'b1; e_req_ready = 1'b1;
    step();

    // SB to lane 3
    do_op(3'd5, 32'h0000_1003, 32'hDEAD_BEEF, 32'd0, 0, 0, 0, 1'b0);
    chk("sb_addr", cap_addr, 32'h0000_1000);
    chk("sb_we", {28'd0, cap_we}, 32'h8);
    chk("sb_wdata", cap_wdata, 32'hEFEF_EFEF);
    chk("sb_rsp", cap_data, 32'd0);

    do_op(3'd0, 32'h0000_2002, 32'd0, 32'h12F4_5678, 0, 0, 0, 1'b0);
    chk("lb_lit", cap_data, 32'hFFFF_FFF4);
    do_op(3'd3, 32'h0000_2002, 32'd0, 32'h12F4_5678, 0, 0, 0, 1'b0);
    chk("lbu_lit", cap_data, 32'h0000_00F4);
    do_op(3'd1, 32'h0000_2002, 32'd0, 32'h12F4_5678, 0, 0, 0, 1'b0);
    chk("lh_lit", cap_data, 32'h0000_12F4);

    do_op(3'd4, 32'h0000_2000, 32'd0, 32'h0000_ABCD, 3, 1, 0, 1'b1);
    chk("lhu_lit", cap_data, 32'h0000_ABCD);

    // Timeout, then a normal op
    do_op(3'd2, 32'h0000_4000, 32'd0, 32'h1111_1111, 0, TO, 0, 1'b0);
    chk("to_err", {31'd0, cap_err}, 32'd1);
    chk("to_data", cap_data, 32'd0);
    do_op(3'd7, 32'h0000_3006, 32'h1122_3344, 32'd0, 1, 0, 1, 1'b0);
    chk("sw_we", {28'd0, cap_we}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'h1122_3344);

    // Response coinciding with the limit cycle
    do_op(3'd2, 32'h0000_4004, 32'd0, 32'h5555_AAAA, 0, TO - 1, 0, 1'b0);
    chk("limit_err", {31'd0, cap_err}, 32'd0);
    chk("limit_data", cap_data, 32'h5555_AAAA);

    do_op(3'd2, 32'h0000_5000, 32'd0, 32'hCAFE_F00D, 0, 2, 5, 1'b1);
    chk("lw_hold", cap_data, 32'hCAFE_F00D);

    for (int i = 0; i < 80; i++) begin
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3),
            1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

    // Reset while a load waits for memory; a later stray response is ignored
    req_valid = 1'b1; addr = 32'h0000_6000; ldst_ctrl = 3'd2; set_idle_exp();
    step();
    req_valid = 1'b0; e_zero = 1'b0; e_req_ready = 1'b0; e_stall = 1'b1; e_dreq = 1'b1;
    e_addr = 32'h0000_6000; e_we = 4'd0; e_wdata = 32'd0; dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0; e_dreq = 1'b0;
    step();
    chk_en = 1'b0; rst_n = 1'b0;
    step();
    set_idle_exp(); e_zero = 1'b1; chk_en = 1'b1;
    step();
    rst_n = 1'b1; e_req_ready = 1'b1;
    dmem_resp_valid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    step();
    dmem_resp_valid = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit for the MIPS pipeline, directly downstream of the address-alignment stage.
- Takes the aligned address, load/store control and store data, and generates byte-lane write enables and a lane-replicated store word.
- Runs a single-outstanding request/response handshake to data memory, then extracts and sign/zero-extends load data for writeback.
- Stalls the pipeline while an access is in flight; flags a memory timeout.

Parameters:
TIMEOUT_CYCLES, 255, WAIT cycles without dmem_resp_valid before aborting a load with err=1 (1..65535)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  memory op present from upstream stage
req_ready  output  1  unit can accept an op (high only in IDLE)
addr  input  32  aligned byte address from upstream (bit0 ignored for halfword, bits1:0 ignored for word)
ldst_ctrl  input  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
store_data  input  32  register value to store (low byte/half used for SB/SH)
dmem_req_valid  output  1  request to data memory
dmem_req_ready  input  1  memory accepts request
dmem_addr  output  32  {addr[31:2],2'b00}
dmem_we  output  4  byte write enables, 4'b0000 for loads
dmem_wdata  output  32  lane-replicated store data
dmem_resp_valid  input  1  load data valid (single cycle)
dmem_rdata  input  32  load word from memory
rsp_valid  output  1  op complete, result valid
rsp_ready  input  1  writeback consumes result
rsp_data  output  32  extended load value; 0 for stores and timeouts
err  output  1  qualifies rsp_valid: load timed out
stall  output  1  high whenever state != IDLE

Behaviour:
- Lane n = bits [8n+7:8n], selected by addr[1:0] (little-endian lane numbering).
- Reset: rst_n low at a rising edge -> state IDLE, timeout counter 0. dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, rsp_valid, rsp_data, err, stall all 0; req_ready=1. Applies mid-operation: any in-flight request is abandoned and a later dmem_resp_valid in IDLE is ignored.
- IDLE:
  - req_ready=1.
  - On req_valid: latch dmem_addr, addr[1:0], ldst_ctrl; compute dmem_we/dmem_wdata; go to ISSUE.
- Store encoding:
  - SB: we = 1 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: we = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{store_data[15:0]}}.
  - SW: we = 4'b1111; wdata = store_data.
  - Loads: we = 0, wdata = 0.
- ISSUE:
  - dmem_req_valid=1; addr, we and wdata held stable until dmem_req_ready.
  - On handshake: store -> RESP (rsp_data=0, err=0); load -> WAIT with counter cleared.
  - dmem_req_valid drops in the cycle after the handshake.
- WAIT:
  - Counter increments each cycle.
  - dmem_resp_valid -> capture the extracted value into rsp_data, go to RESP.
  - If counter == TIMEOUT_CYCLES-1 with no response -> RESP with err=1, rsp_data=0.
  - Response and limit in the same cycle: response wins, err=0.
  - A response arriving in the ISSUE handshake cycle is not legal and is ignored.
- Load extraction:
  - LB: sign-extend lane byte. LBU: zero-extend lane byte.
  - LH: sign-extend rdata[31:16] if addr[1], else rdata[15:0]. LHU: zero-extend the same half.
  - LW: rdata unchanged.
- RESP:
  - rsp_valid=1; rsp_data and err held until rsp_ready, then IDLE.
  - req_ready returns high the cycle after the rsp_ready handshake; no overlap of ops.
- Latency:
  - Load with zero-wait memory: accept edge E0, dmem_req_valid visible E0+, handshake at E1, response at E2, rsp_valid after E2 (minimum 3 edges accept-to-rsp_valid).
  - Store: rsp_valid after the handshake edge (minimum 2 edges).
- stall = (state != IDLE), combinational from state.
- req_ready = (state == IDLE) and rst_n.

Test Plan:
- SB, addr=0x1003, store_data=0xDEADBEEF -> dmem_addr=0x1000, dmem_we=4'b1000, dmem_wdata=0xEFEFEFEF, rsp_valid with rsp_data=0 two edges after accept.
- LB/LBU, addr=0x2002, dmem_rdata=0x12F45678 -> LB rsp_data=0xFFFFFFF4, LBU rsp_data=0x000000F4; LH, addr=0x2002 -> 0x000012F4.
- LHU, addr=0x2000, dmem_rdata=0x0000ABCD, with dmem_req_ready held low 3 cycles -> request fields stable throughout, rsp_data=0x0000ABCD, stall high from accept until the rsp_ready handshake.
- LW with TIMEOUT_CYCLES=4 and no dmem_resp_valid -> rsp_valid, err=1, rsp_data=0 after 4 WAIT cycles; next op accepted normally.
- rsp_ready held low 5 cycles after a LW returning 0xCAFEF00D -> rsp_data stable, req_ready low, new req_valid not accepted until the handshake.
- rst_n pulled low during WAIT, then dmem_resp_valid pulsed after release -> outputs zero, req_ready=1, stray response ignored, no rsp_valid.
